// File: rtl/branch_predict_unit.sv
// Fetch PC register with a direct-mapped 2-bit-counter branch target table,
// plus same-cycle branch resolution, mispredict flush and a saturating mispredict counter.
module branch_predict_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     IDX_W    = 3,
    parameter int unsigned     IMM_W    = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [1:0]      CNT_INIT = 2'b01,
    parameter int unsigned     PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              hlt,
    output logic [PC_W-1:0]   pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic              ex_br,
    input  logic              ex_breg,
    input  logic [2:0]        ex_cond,
    input  logic [2:0]        ex_flags,
    input  logic [IMM_W-1:0]  ex_imm,
    input  logic [PC_W-1:0]   ex_pc_plus2,
    input  logic [PC_W-1:0]   ex_reg_target,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    output logic              br_taken,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [PERF_W-1:0] mispredict_cnt
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = PC_W - IDX_W - 1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PERF_W-1:0] miss_cnt_q;
    logic              valid_q [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [PC_W-1:0]   tgt_q   [DEPTH];
    logic [1:0]        cnt_q   [DEPTH];

    logic [IDX_W-1:0]  f_idx;
    logic              f_hit;
    logic              cond_ok;
    logic [PC_W-1:0]   imm_ext;
    logic [PC_W-1:0]   br_tgt;
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    logic              mis_dir, mis_tgt, mis_nb;

    // Fetch-side lookup, combinational from the PC register
    assign f_idx       = pc_q[IDX_W:1];
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == pc_q[PC_W-1:IDX_W+1]);
    assign pred_taken  = f_hit & cnt_q[f_idx][1];
    assign pred_target = pred_taken ? tgt_q[f_idx] : '0;
    assign pc          = pc_q;

    // Condition evaluation against {N,V,Z}
    always_comb begin
        cond_ok = 1'b0;
        case (ex_cond)
            3'b000: cond_ok = ~ex_flags[0];
            3'b001: cond_ok = ex_flags[0];
            3'b010: cond_ok = ~ex_flags[0] & ~ex_flags[2];
            3'b011: cond_ok = ex_flags[2];
            3'b100: cond_ok = ex_flags[0] | ~ex_flags[2];
            3'b101: cond_ok = ex_flags[0] | ex_flags[2];
            3'b110: cond_ok = ex_flags[1];
            3'b111: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign imm_ext  = {{(PC_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
    assign br_tgt   = ex_breg ? ex_reg_target : ex_pc_plus2 + (imm_ext << 1);
    assign br_taken = ex_valid & ex_br & cond_ok;

    // Table slot of the resolving instruction, addressed by its own PC
    assign u_idx = IDX_W'((ex_pc_plus2 - PC_W'(2)) >> 1);
    assign u_tag = TAG_W'((ex_pc_plus2 - PC_W'(2)) >> (IDX_W + 1));
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign mis_dir     = ex_br & (br_taken != ex_pred_taken);
    assign mis_tgt     = ex_br & br_taken & (br_tgt != ex_pred_target);
    assign mis_nb      = ~ex_br & ex_pred_taken;
    assign flush       = ex_valid & (mis_dir | mis_tgt | mis_nb);
    assign redirect_pc = br_taken ? br_tgt : ex_pc_plus2;

    always_comb begin
        pc_d = pc_q + PC_W'(2);
        if (flush)
            pc_d = redirect_pc;
        else if (hlt || stall)
            pc_d = pc_q;
        else if (pred_taken)
            pc_d = pred_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            miss_cnt_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (flush && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else if (ex_valid) begin
            if (ex_br) begin
                if (u_hit) begin
                    if (br_taken) begin
                        tgt_q[u_idx] <= br_tgt;
                        if (cnt_q[u_idx] != 2'b11)
                            cnt_q[u_idx] <= cnt_q[u_idx] + 2'd1;
                    end else if (cnt_q[u_idx] != 2'b00) begin
                        cnt_q[u_idx] <= cnt_q[u_idx] - 2'd1;
                    end
                end else if (br_taken) begin
                    valid_q[u_idx] <= 1'b1;
                    tag_q[u_idx]   <= u_tag;
                    tgt_q[u_idx]   <= br_tgt;
                    cnt_q[u_idx]   <= 2'b10;
                end
            end else if (ex_pred_taken) begin
                valid_q[u_idx] <= 1'b0;
            end
        end
    end

    assign mispredict_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: resolve-logic vector table plus
// multi-cycle sequences for prediction, counters, flush priority and reset.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        hlt;
    logic [15:0] pc;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        ex_valid;
    logic        ex_br;
    logic        ex_breg;
    logic [2:0]  ex_cond;
    logic [2:0]  ex_flags;
    logic [8:0]  ex_imm;
    logic [15:0] ex_pc_plus2;
    logic [15:0] ex_reg_target;
    logic        ex_pred_taken;
    logic [15:0] ex_pred_target;
    logic        br_taken;
    logic        flush;
    logic [15:0] redirect_pc;
    logic [1:0]  mispredict_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_predict_unit #(
        .PC_W    (16),
        .IDX_W   (3),
        .IMM_W   (9),
        .RESET_PC(16'h0000),
        .CNT_INIT(2'b01),
        .PERF_W  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .hlt           (hlt),
        .pc            (pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_valid      (ex_valid),
        .ex_br         (ex_br),
        .ex_breg       (ex_breg),
        .ex_cond       (ex_cond),
        .ex_flags      (ex_flags),
        .ex_imm        (ex_imm),
        .ex_pc_plus2   (ex_pc_plus2),
        .ex_reg_target (ex_reg_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .br_taken      (br_taken),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .mispredict_cnt(mispredict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic        br;
        logic        breg;
        logic [2:0]  cond;
        logic [2:0]  flags;
        logic [8:0]  imm;
        logic [15:0] pp2;
        logic [15:0] rt;
        logic        pt;
        logic [15:0] ptg;
        logic        e_taken;
        logic        e_flush;
        logic [15:0] e_red;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic br, input logic breg, input logic [2:0] cond,
                           input logic [2:0] flags, input logic [8:0] imm,
                           input logic [15:0] pp2, input logic [15:0] rt,
                           input logic pt, input logic [15:0] ptg);
        ex_valid       = 1'b1;
        ex_br          = br;
        ex_breg        = breg;
        ex_cond        = cond;
        ex_flags       = flags;
        ex_imm         = imm;
        ex_pc_plus2    = pp2;
        ex_reg_target  = rt;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    task automatic idle();
        ex_valid       = 1'b0;
        ex_br          = 1'b0;
        ex_breg        = 1'b0;
        ex_cond        = 3'b000;
        ex_flags       = 3'b000;
        ex_imm         = '0;
        ex_pc_plus2    = '0;
        ex_reg_target  = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Default branch: pp2=0x0012, imm=-3 -> target 0x000C
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b001, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b100, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b101, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b111, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b011, 3'b100, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b101, 3'b100, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b100, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b110, 3'b010, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b110, 3'b101, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b010, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 3'b011, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'hBEEF, 1'b1, 16'h1234, 1'b1, 1'b1, 16'hBEEF};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b1, 16'h000C, 1'b1, 1'b0, 16'h000C};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h000C};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b1, 16'h000C, 1'b0, 1'b1, 16'h0012};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b1, 16'h000C, 1'b0, 1'b1, 16'h0012};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 9'h1FC, 16'h0002, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFA};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 9'h0FF, 16'h0100, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h02FE};
        vecs[23] = '{1'b1, 1'b1, 1'b1, 3'b000, 3'b001, 9'h1FD, 16'h0012, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012};

        rst   = 1'b0;
        stall = 1'b0;
        hlt   = 1'b0;
        idle();

        // Reset state and free run
        do_reset();
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_pred_taken", 32'(pred_taken), 32'h0);
        chk("rst_pred_target", 32'(pred_target), 32'h0000);
        chk("rst_mcnt", 32'(mispredict_cnt), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_br_taken", 32'(br_taken), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("freerun_pc%0d", i), 32'(pc), 32'(2 * i));
        end

        // Resolve logic table
        for (int i = 0; i < 24; i++) begin
            tick();
            resolve(vecs[i].br, vecs[i].breg, vecs[i].cond, vecs[i].flags, vecs[i].imm,
                    vecs[i].pp2, vecs[i].rt, vecs[i].pt, vecs[i].ptg);
            ex_valid = vecs[i].v;
            #1;
            chk($sformatf("vec%0d_taken", i), 32'(br_taken), 32'(vecs[i].e_taken));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_redirect", i), 32'(redirect_pc), 32'(vecs[i].e_red));
        end
        tick();
        idle();

        // First taken branch at 0x0010 allocates, then predicts
        do_reset();
        resolve(1'b1, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000);
        #1;
        chk("first_flush", 32'(flush), 32'h1);
        chk("first_redirect", 32'(redirect_pc), 32'h000C);
        tick();
        chk("first_pc", 32'(pc), 32'h000C);
        idle();
        tick();
        tick();
        chk("refetch_pc", 32'(pc), 32'h0010);
        chk("refetch_pred", 32'(pred_taken), 32'h1);
        chk("refetch_target", 32'(pred_target), 32'h000C);

        // Saturate upward while stalled at 0x0010
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resolve(1'b1, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b1, 16'h000C);
            #1;
            chk($sformatf("sat_flush%0d", i), 32'(flush), 32'h0);
            tick();
            chk($sformatf("sat_pc%0d", i), 32'(pc), 32'h0010);
            chk($sformatf("sat_pred%0d", i), 32'(pred_taken), 32'h1);
        end

        // Two not-taken resolves: 3 -> 2 (still taken) -> 1 (not taken)
        for (int i = 0; i < 2; i++) begin
            resolve(1'b1, 1'b0, 3'b000, 3'b001, 9'h1FD, 16'h0012, 16'h0000, 1'b1, 16'h000C);
            #1;
            chk($sformatf("nt%0d_flush", i), 32'(flush), 32'h1);
            chk($sformatf("nt%0d_redirect", i), 32'(redirect_pc), 32'h0012);
            tick();
            chk($sformatf("nt%0d_pc", i), 32'(pc), 32'h0012);
            resolve(1'b1, 1'b0, 3'b111, 3'b000, 9'd6, 16'h0004, 16'h0000, 1'b0, 16'h0000);
            #1;
            chk($sformatf("helper%0d_redirect", i), 32'(redirect_pc), 32'h0010);
            tick();
            idle();
            chk($sformatf("helper%0d_pc", i), 32'(pc), 32'h0010);
            chk($sformatf("nt%0d_pred", i), 32'(pred_taken), 32'(i == 0));
        end
        chk("nt_final_target", 32'(pred_target), 32'h0000);

        // Non-branch with a taken prediction invalidates its slot
        resolve(1'b0, 1'b0, 3'b111, 3'b000, 9'h000, 16'h0002, 16'h0000, 1'b1, 16'h0000);
        #1;
        chk("nb_flush", 32'(flush), 32'h1);
        chk("nb_redirect", 32'(redirect_pc), 32'h0002);
        tick();
        idle();
        chk("nb_pc", 32'(pc), 32'h0002);
        chk("nb_pred_before", 32'(pred_taken), 32'h1);
        chk("nb_target_before", 32'(pred_target), 32'h0010);
        resolve(1'b0, 1'b0, 3'b111, 3'b000, 9'h000, 16'h0004, 16'h0000, 1'b1, 16'h0000);
        #1;
        chk("nb_no_bypass", 32'(pred_taken), 32'h1);
        tick();
        chk("nb_pc2", 32'(pc), 32'h0004);
        resolve(1'b0, 1'b0, 3'b111, 3'b000, 9'h000, 16'h0002, 16'h0000, 1'b1, 16'h0000);
        tick();
        idle();
        chk("nb_pc3", 32'(pc), 32'h0002);
        chk("nb_pred_after", 32'(pred_taken), 32'h0);

        // Flush beats hlt and stall
        hlt = 1'b1;
        resolve(1'b1, 1'b1, 3'b111, 3'b000, 9'h000, 16'h0042, 16'hBEEF, 1'b1, 16'h1234);
        #1;
        chk("br_flush", 32'(flush), 32'h1);
        chk("br_redirect", 32'(redirect_pc), 32'hBEEF);
        tick();
        chk("br_pc", 32'(pc), 32'hBEEF);
        idle();
        tick();
        chk("hlt_hold_pc", 32'(pc), 32'hBEEF);
        hlt   = 1'b0;
        stall = 1'b0;

        // Saturating mispredict count, then reset mid-update
        do_reset();
        chk("perf_rst", 32'(mispredict_cnt), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            resolve(1'b1, 1'b0, 3'b111, 3'b000, 9'h1FD, 16'h0012, 16'h0000, 1'b0, 16'h0000);
            tick();
            chk($sformatf("perf_cnt%0d", k), 32'(mispredict_cnt), 32'((k > 3) ? 3 : k));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("midrst_pc", 32'(pc), 32'h0000);
        chk("midrst_cnt", 32'(mispredict_cnt), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("midrst_run%0d", i), 32'(pc), 32'(2 * i));
        end
        chk("midrst_pred", 32'(pred_taken), 32'h0);
        tick();
        chk("midrst_after", 32'(pc), 32'h0012);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the fetch-side PC/branch logic of the pipelined CPU. It owns the PC register and predicts next-PC at fetch from a direct-mapped branch history/target table with 2-bit saturating counters. It resolves branches from the pipeline (condition code vs. N/V/Z flags, immediate or register target) and raises a flush with a corrected PC on misprediction. It sits between the IF stage (PC out, prediction out) and the ID/EX branch-resolve point (resolve inputs in).

## Interface
- PC_W, 16, PC/address width
- IDX_W, 3, table index bits; DEPTH = 2**IDX_W entries
- IMM_W, 9, branch immediate width (word offset, signed)
- RESET_PC, 0, PC value after reset
- CNT_INIT, 2'b01, counter value written at reset (weakly not-taken)
- PERF_W, 16, mispredict counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC (pipeline stall)
- hlt  in  1  HLT decoded; hold PC
- pc  out  PC_W  current fetch PC (register)
- pred_taken  out  1  fetch prediction for pc
- pred_target  out  PC_W  predicted target (valid when pred_taken)
- ex_valid  in  1  resolve slot holds a real instruction
- ex_br  in  1  instruction is a branch (B or BR)
- ex_breg  in  1  register-target branch (BR)
- ex_cond  in  3  condition code C
- ex_flags  in  3  {N,V,Z}
- ex_imm  in  IMM_W  signed word offset
- ex_pc_plus2  in  PC_W  resolving instruction address + 2
- ex_reg_target  in  PC_W  register target for BR
- ex_pred_taken  in  1  prediction carried down with the instruction
- ex_pred_target  in  PC_W  predicted target carried down
- br_taken  out  1  resolved taken
- flush  out  1  mispredict; squash younger instructions
- redirect_pc  out  PC_W  corrected fetch PC (valid when flush)
- mispredict_cnt  out  PERF_W  saturating mispredict count

## Operation
- Condition: 000 ~Z; 001 Z; 010 ~Z&~N; 011 N; 100 Z|~N; 101 Z|N; 110 V; 111 always. br_taken = ex_valid & ex_br & cond.
- Target: ex_breg ? ex_reg_target : ex_pc_plus2 + (sext(ex_imm) << 1), truncated mod 2**PC_W (wrap allowed, no overflow flag).
- Table entry: valid, tag = pc[PC_W-1:IDX_W+1], target, 2-bit counter. Index = pc[IDX_W:1]; pc[0] is ignored.
- Lookup (combinational from pc): hit = valid & tag match. pred_taken = hit & counter[1]. pred_target = entry target; it reads 0 when pred_taken = 0.
- Update (ex_valid & ex_br), indexed by ex_pc_plus2 - 2:
  - hit: counter +1 on taken, -1 on not-taken, saturating at 3 and 0; target rewritten when taken.
  - miss + taken: allocate with valid=1, tag, target, counter=2'b10.
  - miss + not-taken: no write.
- Mispredict when ex_valid and any of:
  - ex_br & (br_taken != ex_pred_taken);
  - ex_br & br_taken & target != ex_pred_target;
  - ~ex_br & ex_pred_taken. The entry for that index is invalidated, and redirect_pc = ex_pc_plus2.
- redirect_pc = br_taken ? target : ex_pc_plus2.
- mispredict_cnt increments per flush and saturates at all-ones.
- Next PC priority: rst -> RESET_PC; flush -> redirect_pc; hlt | stall -> hold; else pred_taken ? pred_target : pc + 2.
- The caller deasserts ex_valid during stalls. Each resolve updates the table exactly once.

## Timing
- Reset (1 cycle, synchronous): pc=RESET_PC, all valid=0, counters=CNT_INIT, mispredict_cnt=0. Outputs after reset: pred_taken=0, pred_target=0. flush=0 and br_taken=0 while ex_valid=0.
- pred_taken/pred_target: combinational from the pc register, same cycle.
- br_taken/flush/redirect_pc: combinational from ex_* inputs, same cycle. pc takes redirect_pc at the next edge (1-cycle redirect latency). Table and counter update at the same edge.
- Lookup and update to the same index in one cycle: lookup sees pre-update contents (no bypass).
- flush overrides hlt and stall (the resolving instruction is older). rst overrides everything, including mid-update.

## Test plan
- Reset with rst=1 for 1 cycle -> pc=0x0000, pred_taken=0, mispredict_cnt=0. Free run with no branches -> pc 0,2,4,6.
- Cond sweep: ex_br=1, ex_flags {N,V,Z}=001 -> C=000 not taken, 001 taken, 100 taken, 101 taken, 111 taken. {N,V,Z}=100 -> C=011 and C=101 taken, C=010 not taken.
- First taken B at 0x0010 (ex_pc_plus2=0x0012, imm=-3, pred_taken=0) -> flush=1, redirect_pc=0x000C, pc=0x000C next cycle, counter=2. Refetch of 0x0010 -> pred_taken=1, pred_target=0x000C.
- Counter saturation: resolve that branch taken 3 more times -> counter 3. Then not-taken twice -> counter 1, pred_taken=0 at 0x0010.
- BR with ex_reg_target=0xBEEF, ex_pred_taken=1, ex_pred_target=0x1234 -> flush=1, redirect_pc=0xBEEF. The same cycle with hlt=1 and stall=1 -> pc=0xBEEF next.
- mispredict_cnt with PERF_W=2: 5 forced mispredicts -> count holds at 3. rst asserted mid-run -> count 0, all entries invalid.
